// File: rtl/regfile_sb.sv
// regfile_sb: register file with two async read ports, two sync write
// ports (A = ALU writeback, B = load return), a hard-wired zero register
// and a load scoreboard (per-register pending bits, counter, full flag).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   ra1/ra2 -> rd1/rd2    combinational reads (ZERO_REG reads 0)
//   wea/waa/wda           write port A (wins on address collision)
//   web/wab/wdb           write port B; also clears pending[wab]
//   iss_valid/iss_wa      load issue, sets pending[iss_wa]
//   busy1/busy2           pending bit of ra1/ra2
//   pend_cnt, sb_full     outstanding-load count, count == MAX_PEND
//   iss_drop              registered: an issue was rejected last cycle
//
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding
// on rd1/rd2 and busy suppression on a same-cycle load return.
module regfile_sb #(
  parameter int N        = 64,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = NREG - 1,
  parameter int INIT_IDX = 1,
  parameter int MAX_PEND = 4,
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  input  logic          wea,
  input  logic [AW-1:0] waa,
  input  logic [N-1:0]  wda,
  input  logic          web,
  input  logic [AW-1:0] wab,
  input  logic [N-1:0]  wdb,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_wa,
  output logic          busy1,
  output logic          busy2,
  output logic [CW-1:0] pend_cnt,
  output logic          sb_full,
  output logic          iss_drop
);

  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  logic [N-1:0]    mem [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            accept;
  logic            set_new;
  logic            clr_hit;
  logic            drop_nxt;

  // Scoreboard next state. A set and a clear on the same register in one
  // cycle resolves to "set" with no counter movement.
  always_comb begin
    accept   = iss_valid && (iss_wa != ZA) && (!sb_full || pending[iss_wa]);
    drop_nxt = iss_valid && (iss_wa != ZA) && !accept;
    set_new  = accept && !pending[iss_wa];
    clr_hit  = web && pending[wab] && !(accept && (iss_wa == wab));
    pend_nxt = pending;
    if (web)
      pend_nxt[wab] = 1'b0;
    if (accept)
      pend_nxt[iss_wa] = 1'b1;
    cnt_nxt = pend_cnt + CW'(set_new) - CW'(clr_hit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      pend_cnt <= '0;
      iss_drop <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
      iss_drop <= drop_nxt;
    end
  end

  assign sb_full = (pend_cnt == CW'(MAX_PEND));

  // Port B is written first so a colliding port A write overrides it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++)
        mem[i] <= (INIT_IDX != 0 && AW'(i) != ZA) ? N'(i) : '0;
    end else begin
      if (web && (wab != ZA))
        mem[wab] <= wdb;
      if (wea && (waa != ZA))
        mem[waa] <= wda;
    end
  end

  always_comb begin
    rd1   = (ra1 == ZA) ? '0 : mem[ra1];
    rd2   = (ra2 == ZA) ? '0 : mem[ra2];
    busy1 = (ra1 != ZA) && pending[ra1];
    busy2 = (ra2 != ZA) && pending[ra2];
`ifdef REGFILE_BYPASS_EN
    if (ra1 != ZA) begin
      if (wea && (waa == ra1))
        rd1 = wda;
      else if (web && (wab == ra1))
        rd1 = wdb;
      if (web && (wab == ra1) && !(accept && (iss_wa == ra1)))
        busy1 = 1'b0;
    end
    if (ra2 != ZA) begin
      if (wea && (waa == ra2))
        rd2 = wda;
      else if (web && (wab == ra2))
        rd2 = wdb;
      if (web && (wab == ra2) && !(accept && (iss_wa == ra2)))
        busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus randomized bench for regfile_sb with the
// default configuration (64-bit, 32 registers, zero register 31,
// index-valued reset, 4 outstanding loads). A behavioural model tracks
// register contents and the set of pending registers; outputs are
// compared against it on every falling edge.
module tb_regfile_sb;

  logic        clk;
  logic        reset_n;
  logic [4:0]  ra1, ra2, waa, wab, iss_wa;
  logic [63:0] rd1, rd2, wda, wdb;
  logic        wea, web, iss_valid;
  logic        busy1, busy2, sb_full, iss_drop;
  logic [2:0]  pend_cnt;

  int tests = 0;
  int fails = 0;
  bit run_cmp = 0;

  regfile_sb #(
    .N(64), .NREG(32), .ZERO_REG(31), .INIT_IDX(1), .MAX_PEND(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wea(wea), .waa(waa), .wda(wda),
    .web(web), .wab(wab), .wdb(wdb),
    .iss_valid(iss_valid), .iss_wa(iss_wa),
    .busy1(busy1), .busy2(busy2),
    .pend_cnt(pend_cnt), .sb_full(sb_full), .iss_drop(iss_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] mreg [32];
  bit   [31:0] mpend;
  bit          mdrop;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = (i == 31) ? 64'd0 : 64'(i);
    mpend = '0;
    mdrop = 0;
  endtask

  function automatic int mcount();
    return $countones(mpend);
  endfunction

  function automatic bit m_accept();
    return iss_valid && iss_wa != 5'd31 && (mcount() < 4 || mpend[iss_wa]);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      bit acc;
      acc   = m_accept();
      mdrop = iss_valid && iss_wa != 5'd31 && !acc;
      if (web && wab != 5'd31) mreg[wab] = wdb;
      if (wea && waa != 5'd31) mreg[waa] = wda;
      if (web) mpend[wab] = 0;
      if (acc) mpend[iss_wa] = 1;
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (wea && waa == ra) return wda;
    if (web && wab == ra) return wdb;
`endif
    return mreg[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
    if (web && wab == ra && !(m_accept() && iss_wa == ra)) return 1'b0;
`endif
    return mpend[ra];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("rd1", rd1, exp_rd(ra1));
      check("rd2", rd2, exp_rd(ra2));
      check("busy1", 64'(busy1), 64'(exp_busy(ra1)));
      check("busy2", 64'(busy2), 64'(exp_busy(ra2)));
      check("pend_cnt", 64'(pend_cnt), 64'(mcount()));
      check("sb_full", 64'(sb_full), 64'(mcount() == 4));
      check("iss_drop", 64'(iss_drop), 64'(mdrop));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
    wea = 0; web = 0; iss_valid = 0;
  endtask

  function automatic logic [4:0] rand_addr();
    int a;
    a = $urandom_range(0, 10);
    return (a == 10) ? 5'd31 : 5'(a);
  endfunction

  initial begin
    reset_n = 0;
    ra1 = 0; ra2 = 0; waa = 0; wab = 0; iss_wa = 0;
    wda = 0; wdb = 0; wea = 0; web = 0; iss_valid = 0;
    model_reset();
    run_cmp = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    ra1 = 5; ra2 = 31;
    @(negedge clk);
    check("pin_reset_rd1", rd1, 64'd5);
    check("pin_reset_rd2", rd2, 64'd0);
    check("pin_reset_busy", 64'({busy1, busy2}), 64'd0);
    check("pin_reset_cnt", 64'(pend_cnt), 64'd0);

    // zero register write ignored
    next(); wea = 1; waa = 31; wda = 64'hDEAD; ra1 = 31;
    next(); @(negedge clk);
    check("pin_zero_write", rd1, 64'd0);

    // port collision: A wins
    next(); wea = 1; waa = 3; wda = 64'hAA; web = 1; wab = 3; wdb = 64'hBB; ra1 = 3;
    next(); @(negedge clk);
    check("pin_collide", rd1, 64'hAA);

    // fill the scoreboard
    for (int i = 1; i <= 4; i++) begin
      next(); iss_valid = 1; iss_wa = 5'(i);
    end
    next(); @(negedge clk);
    check("pin_full_cnt", 64'(pend_cnt), 64'd4);
    check("pin_full_flag", 64'(sb_full), 64'd1);
    next(); iss_valid = 1; iss_wa = 5;
    next(); ra1 = 5; iss_valid = 1; iss_wa = 2;
    @(negedge clk);
    check("pin_drop", 64'(iss_drop), 64'd1);
    check("pin_drop_busy5", 64'(busy1), 64'd0);
    next(); @(negedge clk);
    check("pin_reissue_cnt", 64'(pend_cnt), 64'd4);
    check("pin_reissue_nodrop", 64'(iss_drop), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      next(); web = 1; wab = 5'(i); wdb = 64'(i * 16);
    end
    next(); @(negedge clk);
    check("pin_drain_cnt", 64'(pend_cnt), 64'd0);

    // same-cycle set and clear
    next(); iss_valid = 1; iss_wa = 7;
    next(); iss_valid = 1; iss_wa = 7; web = 1; wab = 7; wdb = 64'h77;
    next(); ra1 = 7; @(negedge clk);
    check("pin_setclr_busy", 64'(busy1), 64'd1);
    check("pin_setclr_cnt", 64'(pend_cnt), 64'd1);
    next(); web = 1; wab = 9; wdb = 64'h99;
    next(); @(negedge clk);
    check("pin_clr_idle_cnt", 64'(pend_cnt), 64'd1);
    next(); web = 1; wab = 7;
    next();

    // reset mid-cycle with loads in flight
    for (int i = 1; i <= 3; i++) begin
      next(); iss_valid = 1; iss_wa = 5'(i);
    end
    next();
    #2 reset_n = 0;
    #1 ra1 = 1;
    #0;
    check("pin_rst_cnt", 64'(pend_cnt), 64'd0);
    check("pin_rst_rd1", rd1, 64'd1);
    next(); reset_n = 1; web = 1; wab = 1; wdb = 64'h1234;
    next(); @(negedge clk);
    check("pin_late_cnt", 64'(pend_cnt), 64'd0);
    check("pin_late_data", rd1, 64'h1234);

    // forwarding visibility
    next(); wea = 1; waa = 6; wda = 64'h55; ra1 = 6;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("pin_fwd_same", rd1, 64'h55);
`else
    check("pin_fwd_same", rd1, 64'd6);
`endif
    next(); @(negedge clk);
    check("pin_fwd_next", rd1, 64'h55);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      next();
      ra1 = rand_addr(); ra2 = rand_addr();
      wea = ($urandom_range(0, 9) < 4); waa = rand_addr(); wda = {$urandom, $urandom};
      web = ($urandom_range(0, 9) < 4); wab = rand_addr(); wdb = {$urandom, $urandom};
      iss_valid = ($urandom_range(0, 9) < 5); iss_wa = rand_addr();
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 0;
        #1 reset_n = 1;
      end
    end
    next();
    @(negedge clk);
    #1 run_cmp = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the 2-read/1-write register file for the ARM datapath.
- Two asynchronous read ports and two synchronous write ports: port A for ALU writeback, port B for load writeback.
- A configurable hard-wired zero register.
- A load scoreboard: per-register pending bits, an outstanding-load counter and a full flag, so the decode stage can stall on RAW hazards against in-flight loads.

Parameters:
N, 64, data width in bits
NREG, 32, number of architectural registers (power of two, >= 4)
AW, $clog2(NREG), register address width (derived; do not override)
ZERO_REG, NREG-1, index of the hard-wired zero register
INIT_IDX, 1, 1: register i resets to value i; 0: all registers reset to 0
MAX_PEND, 4, maximum outstanding loads tracked (1..NREG-1)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
ra1  in  AW  read address 1
ra2  in  AW  read address 2
rd1  out  N  read data 1
rd2  out  N  read data 2
wea  in  1  write enable, port A (ALU)
waa  in  AW  write address, port A
wda  in  N  write data, port A
web  in  1  write enable, port B (load return)
wab  in  AW  write address, port B
wdb  in  N  write data, port B
iss_valid  in  1  load issue: mark iss_wa pending
iss_wa  in  AW  destination register of the issued load
busy1  out  1  pending[ra1]
busy2  out  1  pending[ra2]
pend_cnt  out  $clog2(MAX_PEND+1)  number of set pending bits
sb_full  out  1  pend_cnt == MAX_PEND
iss_drop  out  1  registered; an issue was rejected in the previous cycle

Behaviour:
- Reset (reset_n low, asynchronous):
  - reg[i] = INIT_IDX ? i : 0; reg[ZERO_REG] = 0.
  - All pending bits 0; pend_cnt = 0; sb_full = 0; iss_drop = 0.
  - Any write or issue on the edge coinciding with reset is lost.
- Reads:
  - Combinational, zero latency.
  - rd = reg[ra], except ra == ZERO_REG always returns 0.
  - busy reflects the registered pending bit; busy for ZERO_REG is always 0.
- Writes:
  - On posedge, wea writes wda to reg[waa] and web writes wdb to reg[wab].
  - Writes to ZERO_REG are ignored.
  - waa == wab with both enabled: port A wins, since ALU results are younger than a returning load.
- Scoreboard set:
  - An issue is accepted when iss_valid = 1, iss_wa != ZERO_REG, and either sb_full = 0 or pending[iss_wa] is already 1.
  - Accepted issue sets pending[iss_wa] at posedge.
  - Re-issuing to an already pending register leaves pend_cnt unchanged.
- Scoreboard reject:
  - iss_valid with sb_full = 1 and pending[iss_wa] = 0 is rejected; iss_drop = 1 for exactly the next cycle.
  - iss_valid to ZERO_REG is ignored silently, with no drop.
- Scoreboard clear:
  - web = 1 clears pending[wab] at posedge.
  - wea = 1 does not touch pending bits.
- Same-cycle set and clear on one register: set wins; the bit stays 1 and the counter is unchanged.
- pend_cnt:
  - Net delta per cycle is +1 (set only), -1 (clear of a set bit only) or 0.
  - Never exceeds MAX_PEND; never underflows. A clear of a non-pending register is a no-op.
- A port A write to a pending register is allowed: data updates, bit unchanged. This is the WAW case; the hazard unit owns ordering.
- Reset mid-operation: all pending loads are discarded; late load returns after reset write data normally and do not alter the counter.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding in the same cycle.
  - If ra matches an enabled write address (not ZERO_REG), rd returns the write data instead of the array value, with port A having priority over port B.
  - busy is forced to 0 when the same-cycle web clears that register and no same-cycle set targets it.
- Undefined: rd and busy show the pre-edge state; new values are visible the cycle after the write.

Test Plan:
- Reset release with INIT_IDX=1, read ra1=5, ra2=31 -> rd1=5, rd2=0, busy1=busy2=0, pend_cnt=0.
- wea=1, waa=31, wda=0xDEAD, then read 31 -> rd=0; wea=1, waa=3, wda=0xAA, same cycle web=1, wab=3, wdb=0xBB -> next cycle reg3=0xAA.
- Issue loads to x1, x2, x3, x4 on consecutive cycles (MAX_PEND=4) -> pend_cnt=4, sb_full=1; issue x5 -> iss_drop=1 next cycle, pending[5]=0; re-issue x2 -> accepted, pend_cnt=4.
- Pending x7, then same cycle web=1, wab=7 with iss_valid=1, iss_wa=7 -> busy stays 1, pend_cnt unchanged; web to non-pending x9 -> pend_cnt unchanged.
- 3 loads pending, assert reset_n=0 mid-cycle (between edges) -> pend_cnt=0 immediately and registers at index values; after release web to x1 -> pend_cnt stays 0.
- With REGFILE_BYPASS_EN: wea=1, waa=6, wda=0x55, ra1=6 -> rd1=0x55 the same cycle. Without it: rd1=6 that cycle, 0x55 the next.
